mem_arbiter: RTL

Two-master arbiter for the single-port 256×16 data RAM in the CPU top level. Master 0 is the CPU load/store path; master 1 is a secondary requester such as a DMA or display-refresh engine. Each request is a single-word read or write. Master 0 has fixed priority, with starvation protection for master 1. The RAM is driven only through registered outputs, and all responses use a req/ack handshake.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the two-master data-RAM arbiter:
//   - state_t       : arbiter FSM states
//   - M0 / M1       : master identifiers
//   - AW_DEF/DW_DEF : default RAM address/data widths
//   - STARVE_LIMIT_DEF : default count of back-to-back m0 grants tolerated
//                        while m1 waits
package mem_arb_pkg;

    localparam int AW_DEF           = 8;
    localparam int DW_DEF           = 16;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates single-word read/write requests from two masters onto one
// synchronous single-port RAM. Master 0 has fixed priority; master 1 is
// forced a grant once it has been passed over STARVE_LIMIT times in a row.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   m0_*/m1_*  req/we/addr/wdata  master requests (held until ack)
//   m0_ack/m1_ack              one-cycle completion pulse
//   m0_rdata/m1_rdata          read data, valid in ack cycle, held until that
//                              master's next read completes
//   mem_addr/mem_we/mem_wdata  registered RAM command
//   mem_rdata                  RAM read data, one cycle after mem_addr
//   busy                       high while a transaction is in flight
//   state_dbg                  current FSM state, for observation only
//
// Handshake: a master raises req with we/addr/wdata stable and keeps it high
// until it sees ack (a single-cycle pulse). A req still high in the cycle
// after ack is a new request. A req dropped early does not cancel the
// transaction; it completes and ack still pulses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output state_t        state_dbg
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic       cur_id;     // master owning the in-flight transaction
    logic       cur_we;     // mem_we drops after ACCESS, so keep the type here

    logic          grant_any;
    logic          grant_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Next state and grant decision. Only IDLE can grant; the other states
    // walk a fixed four-cycle sequence.
    always_comb begin
        state_nxt = state;
        grant_any = 1'b0;
        grant_id  = M0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_nxt = ACCESS;
                    grant_any = 1'b1;
                    if (m0_req && m1_req)
                        grant_id = (starve_cnt == LIMIT) ? M1 : M0;
                    else
                        grant_id = m1_req ? M1 : M0;
                end
            end
            ACCESS:  state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_we    = (grant_id == M1) ? m1_we    : m0_we;
        sel_addr  = (grant_id == M1) ? m1_addr  : m0_addr;
        sel_wdata = (grant_id == M1) ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            cur_id     <= M0;
            cur_we     <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            state  <= state_nxt;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;

            if (grant_any) begin
                cur_id    <= grant_id;
                cur_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_we    <= sel_we;
                // Count only grants where m1 was actually passed over.
                if (grant_id == M0 && m1_req) begin
                    if (starve_cnt != LIMIT)
                        starve_cnt <= starve_cnt + 4'd1;
                end else begin
                    starve_cnt <= 4'd0;
                end
            end

            if (state == ACCESS)
                mem_we <= 1'b0;

            // RAM output is valid during WAIT; capture it so rdata and ack
            // appear together in RESP.
            if (state == WAIT) begin
                if (!cur_we) begin
                    if (cur_id == M1) m1_rdata <= mem_rdata;
                    else              m0_rdata <= mem_rdata;
                end
                if (cur_id == M1) m1_ack <= 1'b1;
                else              m0_ack <= 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
